// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the I/D-cache memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_e;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    // Byte-offset bits of a line: word index plus the two byte bits.
    function automatic int line_off_bits(input int words);
        return $clog2(words) + 2;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Cache-side and memory-side signals of the shared memory port.
interface mem_port_arbiter_if;

    logic        i_req_valid;
    logic [31:0] i_req_addr;
    logic        i_req_wr;
    logic [31:0] i_wr_data;
    logic [31:0] i_rd_data;
    logic        i_beat_valid;
    logic        i_done;

    logic        d_req_valid;
    logic [31:0] d_req_addr;
    logic        d_req_wr;
    logic [31:0] d_wr_data;
    logic [31:0] d_rd_data;
    logic        d_beat_valid;
    logic        d_done;

    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_wr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_req_data;
    logic        mem_req_ready;

    modport slave (
        input  i_req_valid, i_req_addr, i_req_wr, i_wr_data,
        input  d_req_valid, d_req_addr, d_req_wr, d_wr_data,
        input  mem_req_data, mem_req_ready,
        output i_rd_data, i_beat_valid, i_done,
        output d_rd_data, d_beat_valid, d_done,
        output mem_req_valid, mem_req_addr, mem_req_wr, mem_wr_data
    );

    modport master (
        output i_req_valid, i_req_addr, i_req_wr, i_wr_data,
        output d_req_valid, d_req_addr, d_req_wr, d_wr_data,
        output mem_req_data, mem_req_ready,
        input  i_rd_data, i_beat_valid, i_done,
        input  d_rd_data, d_beat_valid, d_done,
        input  mem_req_valid, mem_req_addr, mem_req_wr, mem_wr_data
    );

endinterface

// File: rtl/mem_port_arbiter_rr2.sv
// Two-way grant: round-robin on last_grant, or D-cache wins ties when FIXED_PRIO is set.
module arb_rr2
    import mem_port_arbiter_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       i_valid_i,
    input  logic       d_valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o       // bit 0 = I, bit 1 = D
);

    always_comb begin
        grant_o = 2'b00;
        if (i_valid_i && d_valid_i) begin
            if (FIXED_PRIO || (last_grant_i == REQ_I)) grant_o = 2'b10;
            else                                       grant_o = 2'b01;
        end else if (i_valid_i) begin
            grant_o = 2'b01;
        end else if (d_valid_i) begin
            grant_o = 2'b10;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between I- and D-cache line transactions, one requester at a time,
// issuing WORDS beats per line and steering read data / beat strobes back to the owner.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WORDS      = 4,
    parameter bit FIXED_PRIO = 1'b0
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam int          BEAT_W    = $clog2(WORDS);
    localparam int          LOB       = line_off_bits(WORDS);
    localparam logic [31:0] OFF_MASK  = (32'd1 << LOB) - 32'd1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS - 1);

    arb_state_e        state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              last_grant_q, last_grant_d;
    logic [31:0]       base_q, base_d;
    logic              wr_q, wr_d;
    logic              mem_valid_q, mem_valid_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       i_rd_q, i_rd_d, d_rd_q, d_rd_d;
    logic              i_beat_q, i_beat_d, d_beat_q, d_beat_d;
    logic              i_done_q, i_done_d, d_done_q, d_done_d;

    logic [1:0]        grant;
    logic              winner;
    logic [31:0]       req_addr;
    logic              hs;
    logic [BEAT_W-1:0] beat_inc;
    logic [31:0]       next_off;

    arb_rr2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
        .i_valid_i    (bus.i_req_valid),
        .d_valid_i    (bus.d_req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    assign winner   = grant[1];
    assign req_addr = winner ? bus.d_req_addr : bus.i_req_addr;
    assign hs       = mem_valid_q & bus.mem_req_ready;
    assign beat_inc = beat_q + BEAT_W'(1);
    // Beat index is OR-ed under the line base so the address can never carry into the tag.
    assign next_off = {{(32-BEAT_W-2){1'b0}}, beat_inc, 2'b00};

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        last_grant_d = last_grant_q;
        base_d       = base_q;
        wr_d         = wr_q;
        mem_valid_d  = mem_valid_q;
        mem_addr_d   = mem_addr_q;
        i_rd_d       = i_rd_q;
        d_rd_d       = d_rd_q;
        i_beat_d     = 1'b0;
        d_beat_d     = 1'b0;
        i_done_d     = 1'b0;
        d_done_d     = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (grant != 2'b00) begin
                    state_d      = winner ? ARB_BUSY_D : ARB_BUSY_I;
                    last_grant_d = winner;
                    base_d       = req_addr & ~OFF_MASK;
                    wr_d         = winner ? bus.d_req_wr : bus.i_req_wr;
                    beat_d       = '0;
                    mem_valid_d  = 1'b1;
                    mem_addr_d   = req_addr & ~OFF_MASK;
                end
            end
            ARB_BUSY_I, ARB_BUSY_D: begin
                if (hs) begin
                    if (state_q == ARB_BUSY_D) begin
                        d_rd_d   = bus.mem_req_data;
                        d_beat_d = 1'b1;
                    end else begin
                        i_rd_d   = bus.mem_req_data;
                        i_beat_d = 1'b1;
                    end
                    if (beat_q == LAST_BEAT) begin
                        state_d     = ARB_IDLE;
                        beat_d      = '0;
                        mem_valid_d = 1'b0;
                        mem_addr_d  = '0;
                        wr_d        = 1'b0;
                        if (state_q == ARB_BUSY_D) d_done_d = 1'b1;
                        else                       i_done_d = 1'b1;
                    end else begin
                        beat_d     = beat_inc;
                        mem_addr_d = base_q | next_off;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ARB_IDLE;
            beat_q       <= '0;
            last_grant_q <= REQ_D;
            base_q       <= '0;
            wr_q         <= 1'b0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            i_rd_q       <= '0;
            d_rd_q       <= '0;
            i_beat_q     <= 1'b0;
            d_beat_q     <= 1'b0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            last_grant_q <= last_grant_d;
            base_q       <= base_d;
            wr_q         <= wr_d;
            mem_valid_q  <= mem_valid_d;
            mem_addr_q   <= mem_addr_d;
            i_rd_q       <= i_rd_d;
            d_rd_q       <= d_rd_d;
            i_beat_q     <= i_beat_d;
            d_beat_q     <= d_beat_d;
            i_done_q     <= i_done_d;
            d_done_q     <= d_done_d;
        end
    end

    assign bus.mem_req_valid = mem_valid_q;
    assign bus.mem_req_addr  = mem_addr_q;
    assign bus.mem_req_wr    = wr_q;
    assign bus.mem_wr_data   = (state_q == ARB_BUSY_I) ? bus.i_wr_data :
                               (state_q == ARB_BUSY_D) ? bus.d_wr_data : 32'd0;
    assign bus.i_rd_data     = i_rd_q;
    assign bus.i_beat_valid  = i_beat_q;
    assign bus.i_done        = i_done_q;
    assign bus.d_rd_data     = d_rd_q;
    assign bus.d_beat_valid  = d_beat_q;
    assign bus.d_done        = d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: round-robin and fixed-priority instances share one stimulus,
// each checked against a transaction-level model with a response scoreboard.
module tb_mem_port_arbiter;

    localparam int WORDS = 4;
    localparam int NDUT  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        i_valid, d_valid, i_wr, d_wr, mem_ready;
    logic [31:0] i_addr, d_addr, i_wd, d_wd, mem_data;
    int          ready_pct, cyc, stall_from, stall_to;
    int          n_tests = 0;
    int          n_fail  = 0;

    mem_port_arbiter_if bus0 ();
    mem_port_arbiter_if bus1 ();

    assign bus0.i_req_valid = i_valid;   assign bus1.i_req_valid = i_valid;
    assign bus0.i_req_addr  = i_addr;    assign bus1.i_req_addr  = i_addr;
    assign bus0.i_req_wr    = i_wr;      assign bus1.i_req_wr    = i_wr;
    assign bus0.i_wr_data   = i_wd;      assign bus1.i_wr_data   = i_wd;
    assign bus0.d_req_valid = d_valid;   assign bus1.d_req_valid = d_valid;
    assign bus0.d_req_addr  = d_addr;    assign bus1.d_req_addr  = d_addr;
    assign bus0.d_req_wr    = d_wr;      assign bus1.d_req_wr    = d_wr;
    assign bus0.d_wr_data   = d_wd;      assign bus1.d_wr_data   = d_wd;
    assign bus0.mem_req_data  = mem_data;  assign bus1.mem_req_data  = mem_data;
    assign bus0.mem_req_ready = mem_ready; assign bus1.mem_req_ready = mem_ready;

    mem_port_arbiter #(.WORDS(WORDS), .FIXED_PRIO(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    mem_port_arbiter #(.WORDS(WORDS), .FIXED_PRIO(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    logic        o_mv[NDUT], o_mw[NDUT], o_ibv[NDUT], o_id[NDUT], o_dbv[NDUT], o_dd[NDUT];
    logic [31:0] o_ma[NDUT], o_mwd[NDUT], o_ird[NDUT], o_drd[NDUT];

    assign o_mv[0]  = bus0.mem_req_valid; assign o_mv[1]  = bus1.mem_req_valid;
    assign o_ma[0]  = bus0.mem_req_addr;  assign o_ma[1]  = bus1.mem_req_addr;
    assign o_mw[0]  = bus0.mem_req_wr;    assign o_mw[1]  = bus1.mem_req_wr;
    assign o_mwd[0] = bus0.mem_wr_data;   assign o_mwd[1] = bus1.mem_wr_data;
    assign o_ird[0] = bus0.i_rd_data;     assign o_ird[1] = bus1.i_rd_data;
    assign o_ibv[0] = bus0.i_beat_valid;  assign o_ibv[1] = bus1.i_beat_valid;
    assign o_id[0]  = bus0.i_done;        assign o_id[1]  = bus1.i_done;
    assign o_drd[0] = bus0.d_rd_data;     assign o_drd[1] = bus1.d_rd_data;
    assign o_dbv[0] = bus0.d_beat_valid;  assign o_dbv[1] = bus1.d_beat_valid;
    assign o_dd[0]  = bus0.d_done;        assign o_dd[1]  = bus1.d_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: one line transaction at a time, per-beat responses queued.
    typedef struct { bit who; logic [31:0] data; bit done; } resp_t;
    resp_t       exp_q[NDUT][$];
    bit          done_log[NDUT][$];
    bit          m_busy[NDUT], m_who[NDUT], m_last[NDUT], m_wr[NDUT];
    logic [31:0] m_base[NDUT];
    int          m_beats[NDUT];
    logic [31:0] m_rd[NDUT][2];

    always @(posedge clk or negedge rst) begin
        bit    w;
        resp_t r;
        if (!rst) begin
            for (int k = 0; k < NDUT; k++) begin
                m_busy[k] = 0; m_last[k] = 1; m_beats[k] = 0; m_wr[k] = 0;
                m_rd[k][0] = '0; m_rd[k][1] = '0;
                exp_q[k].delete();
            end
        end else begin
            for (int k = 0; k < NDUT; k++) begin
                if (!m_busy[k]) begin
                    if (i_valid || d_valid) begin
                        if (i_valid && d_valid) w = (k == 1) ? 1'b1 : !m_last[k];
                        else                    w = d_valid;
                        m_busy[k]  = 1;
                        m_who[k]   = w;
                        m_last[k]  = w;
                        m_beats[k] = 0;
                        m_base[k]  = (w ? d_addr : i_addr) & ~32'(WORDS * 4 - 1);
                        m_wr[k]    = w ? d_wr : i_wr;
                    end
                end else if (mem_ready) begin
                    r.who  = m_who[k];
                    r.data = mem_data;
                    r.done = (m_beats[k] == WORDS - 1);
                    exp_q[k].push_back(r);
                    m_rd[k][m_who[k]] = mem_data;
                    m_beats[k]++;
                    if (m_beats[k] == WORDS) m_busy[k] = 0;
                end
            end
        end
    end

    // Monitor: memory side against model each cycle, cache side against the scoreboard.
    always @(negedge clk) begin
        logic        bv, dn;
        logic [31:0] rd;
        resp_t       r;
        if (rst) begin
            for (int k = 0; k < NDUT; k++) begin
                chk($sformatf("dut%0d mem_req_valid", k), 32'(o_mv[k]), 32'(m_busy[k]));
                if (m_busy[k]) begin
                    chk($sformatf("dut%0d mem_req_addr", k), o_ma[k], m_base[k] + 32'(4 * m_beats[k]));
                    chk($sformatf("dut%0d mem_req_wr", k), 32'(o_mw[k]), 32'(m_wr[k]));
                    chk($sformatf("dut%0d mem_wr_data", k), o_mwd[k], m_who[k] ? d_wd : i_wd);
                end
                for (int s = 0; s < 2; s++) begin
                    bv = (s == 1) ? o_dbv[k] : o_ibv[k];
                    dn = (s == 1) ? o_dd[k]  : o_id[k];
                    rd = (s == 1) ? o_drd[k] : o_ird[k];
                    if (bv || dn) begin
                        if (exp_q[k].size() == 0) begin
                            chk($sformatf("dut%0d side%0d unexpected pulse", k, s), {30'd0, bv, dn}, 32'd0);
                        end else begin
                            r = exp_q[k].pop_front();
                            chk($sformatf("dut%0d pulse owner", k), 32'(s), 32'(r.who));
                            chk($sformatf("dut%0d side%0d beat_valid", k, s), 32'(bv), 32'd1);
                            chk($sformatf("dut%0d side%0d done", k, s), 32'(dn), 32'(r.done));
                            chk($sformatf("dut%0d side%0d rd_data", k, s), rd, r.data);
                        end
                        if (dn) done_log[k].push_back(s == 1);
                    end
                    chk($sformatf("dut%0d side%0d rd_data hold", k, s), rd, m_rd[k][s]);
                end
            end
        end
    end

    always @(posedge clk) begin
        cyc++;
        #1;
        i_wd     = $urandom;
        d_wd     = $urandom;
        mem_data = $urandom;
        if (cyc >= stall_from && cyc < stall_to) mem_ready = 1'b0;
        else mem_ready = ($urandom_range(99) < ready_pct);
    end

    task automatic check_reset(input string tag);
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("%s dut%0d mem_req_valid", tag, k), 32'(o_mv[k]), 32'd0);
            chk($sformatf("%s dut%0d mem_req_addr", tag, k), o_ma[k], 32'd0);
            chk($sformatf("%s dut%0d mem_req_wr", tag, k), 32'(o_mw[k]), 32'd0);
            chk($sformatf("%s dut%0d mem_wr_data", tag, k), o_mwd[k], 32'd0);
            chk($sformatf("%s dut%0d i_rd_data", tag, k), o_ird[k], 32'd0);
            chk($sformatf("%s dut%0d i_beat_valid", tag, k), 32'(o_ibv[k]), 32'd0);
            chk($sformatf("%s dut%0d i_done", tag, k), 32'(o_id[k]), 32'd0);
            chk($sformatf("%s dut%0d d_rd_data", tag, k), o_drd[k], 32'd0);
            chk($sformatf("%s dut%0d d_beat_valid", tag, k), 32'(o_dbv[k]), 32'd0);
            chk($sformatf("%s dut%0d d_done", tag, k), 32'(o_dd[k]), 32'd0);
        end
    endtask

    // Requester: hold valid until done is seen on the round-robin instance, optionally drop early.
    task automatic cache_txn(input bit who, input logic [31:0] addr, input bit wr, input int drop_after);
        int beats = 0;
        bit done  = 0;
        if (who) begin d_addr = addr; d_wr = wr; d_valid = 1'b1; end
        else     begin i_addr = addr; i_wr = wr; i_valid = 1'b1; end
        for (int c = 0; c < 3000 && !done; c++) begin
            @(posedge clk); #1;
            if (who ? o_dbv[0] : o_ibv[0]) beats++;
            if (who ? o_dd[0] : o_id[0]) done = 1;
            if (done || (drop_after > 0 && beats >= drop_after)) begin
                if (who) d_valid = 1'b0; else i_valid = 1'b0;
            end
        end
        chk($sformatf("%s txn @%h completes", who ? "d" : "i", addr), 32'(done), 32'd1);
    endtask

    task automatic settle();
        bit idle = 0;
        for (int c = 0; c < 500 && !idle; c++) begin
            @(posedge clk); #1;
            idle = !m_busy[0] && !m_busy[1] && exp_q[0].size() == 0 && exp_q[1].size() == 0;
        end
        chk("settle to idle", 32'(idle), 32'd1);
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        int nb;
        int seen;
        i_valid = 0; d_valid = 0; i_wr = 0; d_wr = 0; i_addr = 0; d_addr = 0;
        i_wd = 0; d_wd = 0; mem_data = 0; mem_ready = 0;
        ready_pct = 100; cyc = 0; stall_from = 0; stall_to = 0;

        #2 rst = 1'b0;
        #1 check_reset("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        cache_txn(1'b0, 32'h0000_1234, 1'b0, 0);
        settle();

        pulse_reset();
        done_log[0].delete(); done_log[1].delete();
        fork
            cache_txn(1'b0, 32'h2000_0104, 1'b0, 0);
            cache_txn(1'b1, 32'h8000_0040, 1'b0, 0);
        join
        settle();
        chk("rr order count", 32'(done_log[0].size()), 32'd2);
        if (done_log[0].size() == 2) begin
            chk("rr first grant I", 32'(done_log[0][0]), 32'd0);
            chk("rr second grant D", 32'(done_log[0][1]), 32'd1);
        end
        chk("fixed order count", 32'(done_log[1].size()), 32'd2);
        if (done_log[1].size() == 2) begin
            chk("fixed first grant D", 32'(done_log[1][0]), 32'd1);
            chk("fixed second grant D", 32'(done_log[1][1]), 32'd1);
        end

        fork
            cache_txn(1'b1, 32'h4000_0088, 1'b1, 0);
            begin
                seen = 0;
                for (int c = 0; c < 200 && seen == 0; c++) begin
                    @(negedge clk);
                    if (o_dbv[0]) seen = 1;
                end
                chk("stall setup", 32'(seen), 32'd1);
                stall_from = cyc + 1;
                stall_to   = cyc + 4;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall addr held", o_ma[0], 32'h4000_0088);
                    chk("stall wr held", 32'(o_mw[0]), 32'd1);
                    chk("stall valid held", 32'(o_mv[0]), 32'd1);
                end
            end
        join
        settle();

        i_addr = 32'h0000_5678; i_wr = 1'b0; i_valid = 1'b1;
        nb = 0;
        for (int c = 0; c < 200 && nb < 2; c++) begin
            @(posedge clk); #1;
            if (o_ibv[0]) nb++;
        end
        chk("reset test reached beat 2", 32'(nb), 32'd2);
        #2 rst = 1'b0;
        #1 check_reset("async rst");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("idle right after release", 32'(o_mv[0]), 32'd0);
        @(negedge clk);
        chk("restart valid", 32'(o_mv[0]), 32'd1);
        chk("restart at base", o_ma[0], 32'h0000_5670);
        @(posedge clk); #1;
        cache_txn(1'b0, 32'h0000_5678, 1'b0, 0);
        settle();

        ready_pct = 60;
        cache_txn(1'b0, 32'h0000_9ABC, 1'b0, 1);
        settle();

        for (int it = 0; it < 30; it++) begin
            ready_pct = $urandom_range(40, 100);
            fork
                begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    if ($urandom_range(3) != 0) cache_txn(1'b0, $urandom, 1'($urandom_range(1)), 0);
                end
                begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    if ($urandom_range(3) != 0)
                        cache_txn(1'b1, $urandom, 1'($urandom_range(1)), $urandom_range(0, 2));
                end
            join
            settle();
        end

        chk("dut0 scoreboard drained", 32'(exp_q[0].size()), 32'd0);
        chk("dut1 scoreboard drained", 32'(exp_q[1].size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single memory port between the instruction cache and the data cache. Each cache issues whole-line refill or writeback transactions. The block grants one requester at a time, generates the per-beat word addresses for the line, and steers read data and beat strobes back to the granted cache. It sits between the two cache controllers and the memory model/bus, using the cache-side memory handshake (req_valid/req_ready, req_wr, addr, wr_data, rd_data).

Parameters:
WORDS, 4, words per cache line (power of two, 2..16); beats per transaction.
FIXED_PRIO, 0, 0 = round-robin between I and D; 1 = D-cache always wins ties.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
i_req_valid  in  1  I-cache requests a line transaction; held until i_done
i_req_addr  in  32  I-cache line address; low log2(WORDS)+2 bits ignored
i_req_wr  in  1  1 = writeback, 0 = refill (I-cache normally 0)
i_wr_data  in  32  write word for current beat
i_rd_data  out  32  read word of last completed beat
i_beat_valid  out  1  one-cycle pulse per completed beat
i_done  out  1  one-cycle pulse on final beat
d_req_valid, d_req_addr, d_req_wr, d_wr_data, d_rd_data, d_beat_valid, d_done: same as the i_ ports, for the D-cache
mem_req_valid  out  1  beat request to memory
mem_req_addr  out  32  word address of current beat
mem_req_wr  out  1  beat is a write
mem_wr_data  out  32  write data (combinational mux of the granted requester's wr_data)
mem_req_data  in  32  memory read data, valid when mem_req_ready=1
mem_req_ready  in  1  memory accepts or completes the current beat this cycle

Behaviour:
- States: IDLE, BUSY_I, BUSY_D (2-bit encoding). Beat counter `beat` is log2(WORDS) bits. Register `last_grant` holds 0=I, 1=D.
- Reset (rst=0, async): state=IDLE, beat=0, last_grant=D. All outputs 0: mem_req_valid, mem_req_wr, mem_req_addr, both rd_data, both beat_valid, both done.
- IDLE, arbitration:
  - Only one valid: grant it.
  - Both valid with FIXED_PRIO=1: grant D.
  - Both valid with FIXED_PRIO=0: grant the requester that is not last_grant.
  - On grant, at the next edge: latch base = {addr[31:log2(WORDS)+2], zeros}, latch wr, set beat=0, mem_req_valid=1, last_grant=winner, state=BUSY_x.
- Latency: request seen in IDLE at cycle T gives mem_req_valid=1 with mem_req_addr=base at T+1.
- BUSY_x:
  - mem_req_addr = base + beat*4, registered.
  - mem_req_wr = latched wr.
  - mem_wr_data = x_wr_data.
- Beat handshake: a beat completes at an edge where mem_req_valid & mem_req_ready.
  - Next cycle: x_rd_data = mem_req_data (captured even for writes) and x_beat_valid=1 for one cycle.
  - beat increments and the address advances by 4.
- Last beat (beat==WORDS-1 completing):
  - Next cycle: x_done=1 together with x_beat_valid.
  - mem_req_valid=0, beat=0, state=IDLE.
  - At least one idle cycle separates transactions (no back-to-back grant).
- mem_req_ready=0 stalls indefinitely. Address, wr and valid are held, and no timeout is applied.
- Dropping x_req_valid mid-transaction is ignored; the transaction runs to completion (no abort).
- A requester must deassert valid in the cycle i_done/d_done is seen, or it is regranted as a new transaction.
- The non-granted requester's outputs stay 0 while the other is served. Its rd_data keeps its last value.
- mem_req_ready while in IDLE is ignored.
- beat never wraps inside a transaction. Addresses stay within the line and never carry into the tag bits.
- Async reset mid-transaction: immediate return to the reset values. No done pulse is issued, and the requester must re-request.

Decomposition:
- Shared package (e.g. mem_arb_pkg.vh alongside I_Stage.vh) holds:
  - state encodings ARB_IDLE=2'd0, ARB_BUSY_I=2'd1, ARB_BUSY_D=2'd2
  - requester IDs REQ_I=1'b0, REQ_D=1'b1
  - LINE_OFF_BITS derived from WORDS
- One natural sub-module: arb_rr2, the 2-way round-robin/fixed-priority grant logic. Inputs: two valids, last_grant, FIXED_PRIO. Output: one-hot grant.

Test Plan:
- I refill alone: i_req_valid=1, addr=0x0000_1234, mem_req_ready always 1, mem data 0xA0..0xA3. Required: mem addrs 0x1230, 0x1234, 0x1238, 0x123C on consecutive cycles; i_beat_valid 4 pulses with i_rd_data 0xA0..0xA3; i_done with the 4th pulse; D outputs stay 0.
- Simultaneous requests, FIXED_PRIO=0, first after reset. Required: I is granted first (last_grant resets to D). D is granted in the cycle after i_done's idle slot, with d_req_addr=0x8000_0040 producing addrs 0x8000_0040..0x8000_004C.
- Same as the previous scenario with FIXED_PRIO=1. Required: D is granted first and twice in a row if d_req_valid is reasserted, while I waits.
- D writeback, d_req_wr=1, d_wr_data changed per beat to 0x11, 0x22, 0x33, 0x44, with mem_req_ready low for 3 cycles before beat 2. Required: mem_req_wr=1; mem_wr_data matches each beat; address held at base+8 during the stall; d_done after the 4th handshake.
- rst driven low asynchronously mid-beat 2 of an I refill. Required: mem_req_valid and all outputs go to 0 immediately with no i_done. After release with i_req_valid still high, the transaction restarts at base.
- i_req_valid dropped after beat 1. Required: all 4 beats still issued, and i_done pulses.
